// File: rtl/mem_bus_arb.sv
// mem_bus_arb: IC/DC arbiter for the shared proc2mem port, with a 16-entry tag-ownership table.
// Define MEM_ARB_RR_EN for round-robin IDLE contention; otherwise the dcache has fixed priority.
`ifndef XLEN
`define XLEN 32
`endif

package mem_bus_arb_pkg;
  typedef enum logic [1:0] {BUS_NONE = 2'h0, BUS_LOAD = 2'h1, BUS_STORE = 2'h2} BUS_COMMAND;
  typedef enum logic [1:0] {BYTE = 2'h0, HALF = 2'h1, WORD = 2'h2, DOUBLE = 2'h3} MEM_SIZE;
endpackage

module mem_bus_arb
  import mem_bus_arb_pkg::*;
#(
  parameter int MAX_BURST = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  BUS_COMMAND        ic_command,
  input  logic [`XLEN-1:0]  ic_addr,
  input  MEM_SIZE           ic_size,
  output logic [3:0]        ic_response,
  output logic [63:0]       ic_data,
  output logic [3:0]        ic_tag,
  input  BUS_COMMAND        dc_command,
  input  logic [`XLEN-1:0]  dc_addr,
  input  MEM_SIZE           dc_size,
  input  logic [63:0]       dc_wdata,
  output logic [3:0]        dc_response,
  output logic [63:0]       dc_data,
  output logic [3:0]        dc_tag,
  output BUS_COMMAND        proc2mem_command,
  output logic [`XLEN-1:0]  proc2mem_addr,
  output MEM_SIZE           proc2mem_size,
  output logic [63:0]       proc2mem_data,
  input  logic [3:0]        mem2proc_response,
  input  logic [63:0]       mem2proc_data,
  input  logic [3:0]        mem2proc_tag
);
  localparam int CW = $clog2(MAX_BURST + 1);

  typedef enum logic [1:0] {S_IDLE, S_OWN_IC, S_OWN_DC} state_t;
  typedef enum logic {SIDE_IC = 1'b0, SIDE_DC = 1'b1} side_t;

  state_t        state, state_nxt;
  logic [CW-1:0] burst_cnt, burst_nxt;
  side_t         last_win, last_nxt;

  logic  ic_act, dc_act;
  side_t idle_pick, win;
  logic  win_vld, cont, grant_ic, grant_dc;

  logic [15:0] tbl_valid;
  logic [15:0] tbl_owner;  // 1 = dcache
  logic        ret_hit, tbl_set;

  assign ic_act = (ic_command != BUS_NONE);
  assign dc_act = (dc_command != BUS_NONE);

  // Winner when no current owner keeps the bus.
  always_comb begin
    idle_pick = (ic_act && !dc_act) ? SIDE_IC : SIDE_DC;
`ifdef MEM_ARB_RR_EN
    if (ic_act && dc_act) idle_pick = (last_win == SIDE_IC) ? SIDE_DC : SIDE_IC;
`endif
  end

  // NOTE: NBAs make every flop sample pre-edge values, independent of block ordering.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      burst_cnt <= '0;
      last_win  <= SIDE_IC;
    end else begin
      state     <= state_nxt;
      burst_cnt <= burst_nxt;
      last_win  <= last_nxt;
    end
  end

  always_comb begin
    // NOTE: every variable gets a default first so no path through this block infers a latch.
    win_vld   = ic_act || dc_act;
    win       = idle_pick;
    cont      = 1'b0;
    state_nxt = S_IDLE;
    burst_nxt = burst_cnt;
    last_nxt  = last_win;
    case (state)
      S_OWN_IC: if (ic_act) begin
        cont = (burst_cnt < CW'(MAX_BURST)) || !dc_act;
        win  = cont ? SIDE_IC : SIDE_DC;
      end
      S_OWN_DC: if (dc_act) begin
        cont = (burst_cnt < CW'(MAX_BURST)) || !ic_act;
        win  = cont ? SIDE_DC : SIDE_IC;
      end
      default: ;
    endcase
    if (rst) win_vld = 1'b0;
    if (win_vld) begin
      state_nxt = (win == SIDE_IC) ? S_OWN_IC : S_OWN_DC;
      last_nxt  = win;
      if (!cont)                              burst_nxt = CW'(1);
      else if (burst_cnt < CW'(MAX_BURST))    burst_nxt = burst_cnt + CW'(1);
    end
    grant_ic = win_vld && (win == SIDE_IC);
    grant_dc = win_vld && (win == SIDE_DC);
  end

  assign ret_hit = !rst && (mem2proc_tag != 4'd0) && tbl_valid[mem2proc_tag];

  always_comb begin
    proc2mem_command = BUS_NONE;
    proc2mem_addr    = '0;
    proc2mem_size    = DOUBLE;
    proc2mem_data    = '0;
    ic_response      = '0;
    dc_response      = '0;
    if (grant_ic) begin
      proc2mem_command = ic_command;
      proc2mem_addr    = ic_addr;
      proc2mem_size    = ic_size;
      ic_response      = mem2proc_response;
    end else if (grant_dc) begin
      proc2mem_command = dc_command;
      proc2mem_addr    = dc_addr;
      proc2mem_size    = dc_size;
      proc2mem_data    = dc_wdata;
      dc_response      = mem2proc_response;
    end
    ic_tag  = '0;
    ic_data = '0;
    dc_tag  = '0;
    dc_data = '0;
    if (ret_hit) begin
      if (tbl_owner[mem2proc_tag]) begin
        dc_tag  = mem2proc_tag;
        dc_data = mem2proc_data;
      end else begin
        ic_tag  = mem2proc_tag;
        ic_data = mem2proc_data;
      end
    end
  end

  assign tbl_set = (proc2mem_command == BUS_LOAD) && (mem2proc_response != 4'd0);

  // NOTE: the table is only 32 flops, so it is reset like ordinary state; tags issued before reset are dropped.
  always_ff @(posedge clk) begin
    if (rst) begin
      tbl_valid <= '0;
      tbl_owner <= '0;
    end else begin
      if (ret_hit) tbl_valid[mem2proc_tag] <= 1'b0;
      // Placed after the clear so a same-cycle reissue of the returning tag keeps it valid.
      if (tbl_set) begin
        tbl_valid[mem2proc_response] <= 1'b1;
        tbl_owner[mem2proc_response] <= grant_dc;
      end
    end
  end

endmodule

// File: tb/tb_mem_bus_arb.sv
// Bench for mem_bus_arb: directed vector table, hand-written corner sequences, and random
// stimulus checked against a transaction-level model of the arbitration and tag rules.
`ifndef XLEN
`define XLEN 32
`endif

module tb_mem_bus_arb;
  import mem_bus_arb_pkg::*;

  localparam int MAXB = 4;
  localparam int XL   = `XLEN;

  logic              clk = 1'b0;
  logic              rst;
  BUS_COMMAND        ic_command, dc_command, proc2mem_command;
  logic [XL-1:0]     ic_addr, dc_addr, proc2mem_addr;
  MEM_SIZE           ic_size, dc_size, proc2mem_size;
  logic [63:0]       dc_wdata, proc2mem_data, mem2proc_data, ic_data, dc_data;
  logic [3:0]        ic_response, dc_response, ic_tag, dc_tag, mem2proc_response, mem2proc_tag;

  always #5 clk = ~clk;

  mem_bus_arb #(.MAX_BURST(MAXB)) dut (
    .clk(clk), .rst(rst),
    .ic_command(ic_command), .ic_addr(ic_addr), .ic_size(ic_size),
    .ic_response(ic_response), .ic_data(ic_data), .ic_tag(ic_tag),
    .dc_command(dc_command), .dc_addr(dc_addr), .dc_size(dc_size), .dc_wdata(dc_wdata),
    .dc_response(dc_response), .dc_data(dc_data), .dc_tag(dc_tag),
    .proc2mem_command(proc2mem_command), .proc2mem_addr(proc2mem_addr),
    .proc2mem_size(proc2mem_size), .proc2mem_data(proc2mem_data),
    .mem2proc_response(mem2proc_response), .mem2proc_data(mem2proc_data),
    .mem2proc_tag(mem2proc_tag)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(string name, logic [63:0] got, logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Model: holder/run track who owns the bus and for how many cycles; owner[] maps tag -> side.
  int m_holder, m_run, m_last, m_win;  // sides: 0 none, 1 icache, 2 dcache
  int m_owner [16];
  BUS_COMMAND x_cmd;
  logic [XL-1:0] x_addr;
  MEM_SIZE x_size;
  logic [63:0] x_pdata, x_icd, x_dcd;
  logic [3:0] x_icr, x_dcr, x_ict, x_dct;

  task automatic model_reset();
    m_holder = 0; m_run = 0; m_last = 1;
    for (int i = 0; i < 16; i++) m_owner[i] = 0;
  endtask

  task automatic model_eval();
    bit ia, da, holder_act, other_act;
    ia = (ic_command != BUS_NONE);
    da = (dc_command != BUS_NONE);
    holder_act = (m_holder == 1) ? ia : (m_holder == 2) ? da : 1'b0;
    other_act  = (m_holder == 1) ? da : (m_holder == 2) ? ia : 1'b0;
    if (rst) m_win = 0;
    else if (holder_act) m_win = (m_run >= MAXB && other_act) ? 3 - m_holder : m_holder;
    else if (ia && da) begin
`ifdef MEM_ARB_RR_EN
      m_win = 3 - m_last;
`else
      m_win = 2;
`endif
    end else m_win = ia ? 1 : (da ? 2 : 0);
    x_cmd = BUS_NONE; x_addr = '0; x_size = DOUBLE; x_pdata = '0; x_icr = '0; x_dcr = '0;
    if (m_win == 1) begin
      x_cmd = ic_command; x_addr = ic_addr; x_size = ic_size; x_icr = mem2proc_response;
    end else if (m_win == 2) begin
      x_cmd = dc_command; x_addr = dc_addr; x_size = dc_size; x_pdata = dc_wdata;
      x_dcr = mem2proc_response;
    end
    x_ict = '0; x_dct = '0; x_icd = '0; x_dcd = '0;
    if (!rst && mem2proc_tag != 0 && m_owner[mem2proc_tag] == 1) begin
      x_ict = mem2proc_tag; x_icd = mem2proc_data;
    end else if (!rst && mem2proc_tag != 0 && m_owner[mem2proc_tag] == 2) begin
      x_dct = mem2proc_tag; x_dcd = mem2proc_data;
    end
  endtask

  task automatic model_commit();
    if (rst) model_reset();
    else begin
      if (mem2proc_tag != 0) m_owner[mem2proc_tag] = 0;
      if (m_win != 0 && x_cmd == BUS_LOAD && mem2proc_response != 0)
        m_owner[mem2proc_response] = m_win;
      if (m_win == 0) begin
        m_holder = 0; m_run = 0;
      end else begin
        m_run    = (m_win == m_holder) ? ((m_run < MAXB) ? m_run + 1 : MAXB) : 1;
        m_holder = m_win;
        m_last   = m_win;
      end
    end
  endtask

  task automatic settle();
    #3;
    model_eval();
  endtask

  task automatic tick();
    model_commit();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(logic r, BUS_COMMAND ic_c, logic [XL-1:0] ic_a, BUS_COMMAND dc_c,
                       logic [XL-1:0] dc_a, logic [63:0] wd, logic [3:0] mr, logic [3:0] mt,
                       logic [63:0] md);
    rst = r;
    ic_command = ic_c; ic_addr = ic_a; ic_size = WORD;
    dc_command = dc_c; dc_addr = dc_a; dc_size = DOUBLE; dc_wdata = wd;
    mem2proc_response = mr; mem2proc_tag = mt; mem2proc_data = md;
    settle();
  endtask

  task automatic idle(logic r);
    drive(r, BUS_NONE, '0, BUS_NONE, '0, '0, 4'd0, 4'd0, '0);
    tick();
  endtask

  task automatic check_model(string p);
    check({p, "_cmd"}, proc2mem_command, x_cmd);
    check({p, "_addr"}, proc2mem_addr, x_addr);
    if (!rst) check({p, "_size"}, proc2mem_size, x_size);
    check({p, "_pdata"}, proc2mem_data, x_pdata);
    check({p, "_ic_resp"}, ic_response, x_icr);
    check({p, "_dc_resp"}, dc_response, x_dcr);
    check({p, "_ic_tag"}, ic_tag, x_ict);
    check({p, "_dc_tag"}, dc_tag, x_dct);
    check({p, "_ic_data"}, ic_data, x_icd);
    check({p, "_dc_data"}, dc_data, x_dcd);
  endtask

  typedef struct {
    string name;
    BUS_COMMAND ic_c; logic [XL-1:0] ic_a;
    BUS_COMMAND dc_c; logic [XL-1:0] dc_a; logic [63:0] wd;
    logic [3:0] mr, mt; logic [63:0] md;
    BUS_COMMAND e_cmd; logic [XL-1:0] e_addr; logic [63:0] e_pdata;
    logic [3:0] e_icr, e_dcr, e_ict, e_dct; logic [63:0] e_icd, e_dcd;
  } vec_t;

  function automatic vec_t mk(string n, BUS_COMMAND ic_c, logic [XL-1:0] ic_a, BUS_COMMAND dc_c,
                              logic [XL-1:0] dc_a, logic [63:0] wd, logic [3:0] mr,
                              logic [3:0] mt, logic [63:0] md, BUS_COMMAND e_cmd,
                              logic [XL-1:0] e_addr, logic [63:0] e_pdata, logic [3:0] e_icr,
                              logic [3:0] e_dcr, logic [3:0] e_ict, logic [3:0] e_dct,
                              logic [63:0] e_icd, logic [63:0] e_dcd);
    vec_t v;
    v.name = n; v.ic_c = ic_c; v.ic_a = ic_a; v.dc_c = dc_c; v.dc_a = dc_a; v.wd = wd;
    v.mr = mr; v.mt = mt; v.md = md; v.e_cmd = e_cmd; v.e_addr = e_addr; v.e_pdata = e_pdata;
    v.e_icr = e_icr; v.e_dcr = e_dcr; v.e_ict = e_ict; v.e_dct = e_dct;
    v.e_icd = e_icd; v.e_dcd = e_dcd;
    return v;
  endfunction

  vec_t vecs[$];
  BUS_COMMAND rc_ic, rc_dc;

  function automatic BUS_COMMAND rnd_cmd();
    int r;
    r = int'($urandom_range(0, 4));
    return (r < 2) ? BUS_NONE : (r < 4) ? BUS_LOAD : BUS_STORE;
  endfunction

  initial begin
    vecs.push_back(mk("ic_ld_1000", BUS_LOAD, 'h1000, BUS_NONE, 0, 0, 1, 0, 0, BUS_LOAD, 'h1000, 0, 1, 0, 0, 0, 0, 0));
    vecs.push_back(mk("ic_ld_1008", BUS_LOAD, 'h1008, BUS_NONE, 0, 0, 2, 0, 0, BUS_LOAD, 'h1008, 0, 2, 0, 0, 0, 0, 0));
    vecs.push_back(mk("ic_ld_1010", BUS_LOAD, 'h1010, BUS_NONE, 0, 0, 3, 0, 0, BUS_LOAD, 'h1010, 0, 3, 0, 0, 0, 0, 0));
    vecs.push_back(mk("ic_ld_1018", BUS_LOAD, 'h1018, BUS_NONE, 0, 0, 4, 0, 0, BUS_LOAD, 'h1018, 0, 4, 0, 0, 0, 0, 0));
    vecs.push_back(mk("ret_tag3", BUS_NONE, 0, BUS_NONE, 0, 0, 0, 3, 'hDEAD, BUS_NONE, 0, 0, 0, 0, 3, 0, 'hDEAD, 0));
    vecs.push_back(mk("dc_busy", BUS_NONE, 0, BUS_LOAD, 'h2000, 'h1111, 0, 0, 0, BUS_LOAD, 'h2000, 'h1111, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk("ret_tag0", BUS_NONE, 0, BUS_NONE, 0, 0, 0, 0, 'h5555, BUS_NONE, 0, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk("dc_st_tag7", BUS_NONE, 0, BUS_STORE, 'h3000, 'hCAFE, 7, 0, 0, BUS_STORE, 'h3000, 'hCAFE, 0, 7, 0, 0, 0, 0));
    vecs.push_back(mk("ret_store7", BUS_NONE, 0, BUS_NONE, 0, 0, 0, 7, 'h77, BUS_NONE, 0, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk("ic_ld_tag5", BUS_LOAD, 'h4000, BUS_NONE, 0, 0, 5, 0, 0, BUS_LOAD, 'h4000, 0, 5, 0, 0, 0, 0, 0));
    vecs.push_back(mk("reuse_tag5", BUS_NONE, 0, BUS_LOAD, 'h5000, 'h2222, 5, 5, 'hAAAA, BUS_LOAD, 'h5000, 'h2222, 0, 5, 5, 0, 'hAAAA, 0));
    vecs.push_back(mk("ret5_to_dc", BUS_NONE, 0, BUS_NONE, 0, 0, 0, 5, 'hBBBB, BUS_NONE, 0, 0, 0, 0, 0, 5, 0, 'hBBBB));
    vecs.push_back(mk("ret_tag1", BUS_NONE, 0, BUS_NONE, 0, 0, 0, 1, 'h11, BUS_NONE, 0, 0, 0, 0, 1, 0, 'h11, 0));

    model_reset();
    // Reset outputs: active requests and a returning tag must all be masked.
    drive(1'b1, BUS_LOAD, 'h10, BUS_STORE, 'h20, 'h99, 4'd3, 4'd3, 'h1234);
    check("rst_cmd", proc2mem_command, BUS_NONE);
    check("rst_addr", proc2mem_addr, 0);
    check("rst_pdata", proc2mem_data, 0);
    check("rst_ic_resp", ic_response, 0);
    check("rst_dc_resp", dc_response, 0);
    check("rst_ic_tag", ic_tag, 0);
    check("rst_dc_tag", dc_tag, 0);
    tick();
    idle(1'b1);

    foreach (vecs[i]) begin
      drive(1'b0, vecs[i].ic_c, vecs[i].ic_a, vecs[i].dc_c, vecs[i].dc_a, vecs[i].wd,
            vecs[i].mr, vecs[i].mt, vecs[i].md);
      check({vecs[i].name, "_cmd"}, proc2mem_command, vecs[i].e_cmd);
      check({vecs[i].name, "_addr"}, proc2mem_addr, vecs[i].e_addr);
      check({vecs[i].name, "_pdata"}, proc2mem_data, vecs[i].e_pdata);
      check({vecs[i].name, "_ic_resp"}, ic_response, vecs[i].e_icr);
      check({vecs[i].name, "_dc_resp"}, dc_response, vecs[i].e_dcr);
      check({vecs[i].name, "_ic_tag"}, ic_tag, vecs[i].e_ict);
      check({vecs[i].name, "_dc_tag"}, dc_tag, vecs[i].e_dct);
      check({vecs[i].name, "_ic_data"}, ic_data, vecs[i].e_icd);
      check({vecs[i].name, "_dc_data"}, dc_data, vecs[i].e_dcd);
      tick();
    end

    // Burst limit: IC from cycle 0, DC from cycle 1; IC holds cycles 0-3, DC takes cycle 4 on.
    idle(1'b1);
    for (int c = 0; c < 6; c++) begin
      drive(1'b0, BUS_LOAD, XL'(32'h100 + 8 * c), (c >= 1) ? BUS_LOAD : BUS_NONE, 'h200, 0,
            4'd9, 4'd0, 0);
      check($sformatf("burst_c%0d_ic_resp", c), ic_response, (c <= 3) ? 4'd9 : 4'd0);
      check($sformatf("burst_c%0d_dc_resp", c), dc_response, (c >= 4) ? 4'd9 : 4'd0);
      check($sformatf("burst_c%0d_addr", c), proc2mem_addr, (c <= 3) ? XL'(32'h100 + 8 * c) : XL'(32'h200));
      tick();
    end

    // IDLE contention: first goes to DC in both modes; second goes to IC only with round-robin.
    idle(1'b1);
    idle(1'b0);
    drive(1'b0, BUS_LOAD, 'hA0, BUS_LOAD, 'hB0, 0, 4'd6, 4'd0, 0);
    check("cont1_ic_resp", ic_response, 0);
    check("cont1_dc_resp", dc_response, 6);
    check("cont1_addr", proc2mem_addr, 'hB0);
    tick();
    idle(1'b0);
    drive(1'b0, BUS_LOAD, 'hA0, BUS_LOAD, 'hB0, 0, 4'd6, 4'd0, 0);
`ifdef MEM_ARB_RR_EN
    check("cont2_ic_resp", ic_response, 6);
    check("cont2_dc_resp", dc_response, 0);
    check("cont2_addr", proc2mem_addr, 'hA0);
`else
    check("cont2_ic_resp", ic_response, 0);
    check("cont2_dc_resp", dc_response, 6);
    check("cont2_addr", proc2mem_addr, 'hB0);
`endif
    tick();

    // Reset during the second IC request: bus goes quiet and earlier tags are forgotten.
    idle(1'b1);
    drive(1'b0, BUS_LOAD, 'h1000, BUS_NONE, 0, 0, 4'd1, 4'd0, 0);
    check("mid_rst_req1", ic_response, 1);
    tick();
    drive(1'b1, BUS_LOAD, 'h1008, BUS_NONE, 0, 0, 4'd2, 4'd0, 0);
    check("mid_rst_in_cmd", proc2mem_command, BUS_NONE);
    check("mid_rst_in_resp", ic_response, 0);
    tick();
    drive(1'b0, BUS_NONE, 0, BUS_NONE, 0, 0, 4'd0, 4'd0, 0);
    check("mid_rst_after_cmd", proc2mem_command, BUS_NONE);
    tick();
    drive(1'b0, BUS_NONE, 0, BUS_NONE, 0, 0, 4'd0, 4'd2, 'hBEEF);
    check("mid_rst_tag2_ic", ic_tag, 0);
    check("mid_rst_tag2_dc", dc_tag, 0);
    tick();
    drive(1'b0, BUS_NONE, 0, BUS_NONE, 0, 0, 4'd0, 4'd1, 'hBEEF);
    check("mid_rst_tag1_ic", ic_tag, 0);
    check("mid_rst_tag1_ic_data", ic_data, 0);
    tick();

    // Random traffic; commands tend to persist so bursts and forced hand-overs occur.
    rc_ic = BUS_NONE;
    rc_dc = BUS_NONE;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 3) == 0) rc_ic = rnd_cmd();
      if ($urandom_range(0, 3) == 0) rc_dc = rnd_cmd();
      rst = ($urandom_range(0, 99) == 0);
      ic_command = rc_ic; ic_addr = XL'($urandom); ic_size = MEM_SIZE'($urandom_range(0, 3));
      dc_command = rc_dc; dc_addr = XL'($urandom); dc_size = MEM_SIZE'($urandom_range(0, 3));
      dc_wdata = {$urandom, $urandom};
      mem2proc_response = ($urandom_range(0, 3) == 0) ? 4'd0 : 4'($urandom_range(1, 15));
      mem2proc_tag = ($urandom_range(0, 1) == 0) ? 4'd0 : 4'($urandom_range(1, 15));
      mem2proc_data = {$urandom, $urandom};
      settle();
      check_model("rand");
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_bus_arb.md
# mem_bus_arb

Two-requester arbiter sharing the single processor-side memory port between the instruction-cache controller and the data-cache controller. It forwards one granted request per cycle and returns the memory's accept tag to the granted side. It keeps a 16-entry tag-ownership table so that returned load data is steered to the requester that issued it. It sits between both L1 controllers and the `proc2mem_*`/`mem2proc_*` bus.

## Interface
Parameters:
- `MAX_BURST`, 4: maximum consecutive cycles one requester keeps the grant while the other is waiting.

Ports:
- `clk` in 1: clock, all state on rising edge.
- `rst` in 1: synchronous reset, active-high.
- `ic_command` in BUS_COMMAND: icache request.
- `ic_addr` in `XLEN`: icache address.
- `ic_size` in MEM_SIZE: icache size.
- `ic_response` out 4: accept tag for the icache; 0 means not accepted.
- `ic_data` out 64: returned data for the icache.
- `ic_tag` out 4: returned-data tag for the icache; 0 means none.
- `dc_command`, `dc_addr`, `dc_size`: same as the icache inputs, for the dcache.
- `dc_wdata` in 64: dcache store data.
- `dc_response`, `dc_data`, `dc_tag` out: same as the icache outputs, for the dcache.
- `proc2mem_command` out BUS_COMMAND, `proc2mem_addr` out `XLEN`, `proc2mem_size` out MEM_SIZE, `proc2mem_data` out 64: to memory.
- `mem2proc_response` in 4, `mem2proc_data` in 64, `mem2proc_tag` in 4: from memory.

## Operation
- A requester is active when its command != BUS_NONE.
- State machine: IDLE, OWN_IC, OWN_DC. Also holds `burst_cnt` (saturating at MAX_BURST) and `last_win` (IC/DC).
- The grant is combinational from the state and the active inputs.
- IDLE:
  - No active requester: grant none.
  - One active requester: grant it.
  - Both active: the policy picks the winner.
  - When granting, next state is OWN_winner, `burst_cnt`=1, `last_win`=winner.
- OWN_X, X active, and either `burst_cnt`<MAX_BURST or the other side is idle: grant X; `burst_cnt`++ (saturating).
- OWN_X, X active, `burst_cnt`==MAX_BURST, other side active: grant the other side; next state OWN_other, `burst_cnt`=1.
- OWN_X, X idle: arbitrate exactly as IDLE in the same cycle (no bubble). If nothing is active, next state is IDLE.
- Granted requester:
  - Its command, addr and size are driven onto `proc2mem_*`.
  - `proc2mem_data` = `dc_wdata` when DC is granted, else 0.
  - Its `*_response` = `mem2proc_response`.
- Non-granted requester: `*_response`=0 and it must retry.
- No grant: all `proc2mem_*` = BUS_NONE/0 (size DOUBLE).
- Tag table, 16 × {valid, owner}:
  - Set: granted command is BUS_LOAD and `mem2proc_response`!=0 → set entry[response] = {1, grantee}.
  - Stores are never recorded.
  - Return: `mem2proc_tag`!=0 and entry valid → drive that tag and `mem2proc_data` on the owner's `*_tag`/`*_data`; clear the entry.
  - Unowned or invalid return: dropped; both `*_tag`=0.
  - Non-owner `*_data`=0.
- Same-cycle set and clear of the same tag: the set wins.

## Timing
- Request to memory: 0 cycles (combinational pass-through of the granted request).
- Accept tag: same cycle as the request.
- Data steering: same cycle as `mem2proc_tag`.
- Reset values: state IDLE, `burst_cnt`=0, `last_win`=IC, all table entries invalid.
- Output values while in reset: every output 0 / BUS_NONE.
- Reset mid-burst: next cycle in IDLE; tags returned afterwards are dropped.

## Configuration
- `MEM_ARB_RR_EN` defined: IDLE contention goes to the side ≠ `last_win` (round-robin).
- `MEM_ARB_RR_EN` undefined: fixed priority, DC always wins IDLE contention.
- MAX_BURST forcing applies in both modes.

## Test plan
- IC-only burst: IC loads 0x1000, 0x1008, 0x1010, 0x1018; memory responds 1,2,3,4. → `ic_response` 1..4, `dc_response`=0. Later `mem2proc_tag`=3 with data 0xDEAD → `ic_tag`=3, `ic_data`=0xDEAD, `dc_tag`=0.
- IDLE contention, both BUS_LOAD:
  - Without RR: DC granted, `ic_response`=0.
  - With RR after reset: DC granted (`last_win`=IC). Repeat contention from IDLE → IC granted.
- Burst limit: IC active continuously from cycle 0, DC active from cycle 1. → IC granted cycles 0–3, DC granted cycle 4.
- Memory busy: granted DC load with `mem2proc_response`=0 → `dc_response`=0, no table entry; later tag 0 return ignored.
- Tag reuse: DC store accepted with tag 7, then `mem2proc_tag`=7 → both `*_tag`=0. Separately, tag 5 returns to IC in the same cycle a DC load is accepted with tag 5 → `ic_tag`=5 that cycle; the next return of tag 5 goes to DC.
- Reset mid-burst: assert `rst` during the 2nd IC request → next cycle `proc2mem_command`=BUS_NONE; a subsequent `mem2proc_tag`=2 yields `ic_tag`=0 and `dc_tag`=0.
